j1b_ram_arbiter: RTL and testbench
==================================

Name: j1b_ram_arbiter

Overview:
- Shares the single data port of the j1b 32-bit word RAM (8192 words) between two requesters.
  - Port A: the CPU data path (memory fetch/store).
  - Port B: a host loader/DMA engine that fills or dumps RAM over the UART link.
- Decides grant ownership each cycle: round-robin between A and B, plus a bounded burst lock for B.
- Tracks read returns on the RAM's one-cycle read latency and routes each return to the requester that issued it.

Parameters:
- AW, 13, word address width (8192 words).
- DW, 32, data width.
- MAX_BURST, 16, maximum consecutive locked grants to B while A is waiting.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  A access request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  in  1  A write enable (1 = write, 0 = read).
- a_addr  in  AW  A word address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  A access performed this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered, one cycle after a granted read).
- a_rdata  out  DW  A read data.
- b_req, b_we, b_addr, b_wdata  in  1/1/AW/DW  B request, same rules as A.
- b_lock  in  1  B requests burst ownership (sampled with b_req).
- b_gnt, b_rvalid, b_rdata  out  1/1/DW  B grant and return, same rules as A.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset state (asynchronous):
  - Registers: last_gnt=B (so A wins the first conflict), locked=0, burst_cnt=0, a_rvalid=0, b_rvalid=0, rd_owner=none.
  - While reset is high: a_gnt=b_gnt=0 and ram_en=0. No RAM write can occur during reset.
- Grant decision (combinational, same cycle as the request):
  - Lock hold: if locked=1, b_req=1, b_lock=1, and either a_req=0 or burst_cnt<MAX_BURST, grant B.
  - Otherwise, only one requester active: grant it.
  - Otherwise, both active: grant the requester that is not last_gnt.
  - Nothing active: no grant and ram_en=0.
- Exactly one grant per cycle at most; a_gnt and b_gnt are never both 1.
- RAM muxing:
  - ram_en = a_gnt|b_gnt.
  - ram_we, ram_addr and ram_wdata come from the granted port.
  - With no grant, ram_we=0 and address/data are don't-care.
- Per-edge register updates:
  - last_gnt takes the winner whenever a grant occurs.
  - locked: set when B is granted with b_lock=1. Cleared when a cycle passes without b_gnt&b_lock, or when burst_cnt reaches MAX_BURST with a_req=1.
  - burst_cnt: increments on each locked B grant while a_req=1, saturating at MAX_BURST. Cleared whenever locked clears.
  - Burst limit: A is guaranteed a grant within MAX_BURST+1 cycles of asserting a_req. On the limit cycle A wins because locked=0, and last_gnt=B sends the conflict to A.
  - B with b_lock=1 and a_req=0 holds the port indefinitely; burst_cnt stays 0.
- Read return:
  - Granted read (we=0): rd_owner is registered, and next cycle exactly one of a_rvalid/b_rvalid pulses for one cycle.
  - a_rdata = b_rdata = ram_rdata, passed through. Data is only meaningful when the matching rvalid is high.
  - Granted write: no rvalid pulse.
  - Back-to-back reads alternating A/B each return in order, one per cycle, with no bubbles.
- Simultaneous events:
  - A read granted in cycle N and a B write granted in cycle N+1: A's rvalid in N+1 reflects pre-write data, per RAM read-before-write.
  - Request dropped before grant: no access and no rvalid.
- Reset mid-operation: any pending rvalid is cancelled, and the lock and counter are cleared.
- Address or data changes while a request waits ungranted are illegal. Bench assertion: inputs stable while req=1 and gnt=0.

Test Plan:
- Reset, then A writes 0x12345678 to word 5 while b_req=0 → a_gnt=1 same cycle; ram_we=1, ram_addr=5. A reads word 5 next cycle → a_rvalid=1 one cycle later with a_rdata=0x12345678; b_rvalid stays 0.
- A and B request continuously with b_lock=0, starting after reset → grants alternate A,B,A,B… with the first grant to A. Each read's rvalid goes only to its issuer, one per cycle.
- B holds b_lock=1 with back-to-back requests while A requests from cycle 0, MAX_BURST=16 → B is granted 16 consecutive cycles after locking, then A is granted exactly on the following cycle, then B again.
- B holds b_lock=1 with a_req=0 for 40 cycles → b_gnt=1 all 40 cycles and burst_cnt stays 0. a_req rises → A is granted within 17 cycles.
- A read to word 9 is granted and reset is asserted in the next cycle → a_rvalid forced 0 immediately, both gnt=0 and ram_en=0 while reset is high. After release, last_gnt=B.
- A read of word 3 in cycle N and a B write of 0xDEADBEEF to word 3 in cycle N+1 → a_rdata in N+1 equals the old value. A later A read returns 0xDEADBEEF.

Source files
------------

// File: rtl/j1b_ram_arbiter.sv
// Shares the j1b word RAM data port between the CPU (A) and the host loader (B).
// Round-robin arbitration with a bounded burst lock for B and read-return routing.
module j1b_ram_arbiter #(
   parameter int unsigned AW        = 13,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   input  logic          b_lock,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;
   typedef enum logic {SEL_A, SEL_B} sel_t;

   sel_t          last_gnt;
   logic          locked;
   logic [CW-1:0] burst_cnt;
   owner_t        rd_owner;

   logic          lock_hold;
   logic [CW-1:0] cnt_inc;

   // Grant decision: lock hold first, then single requester, then round-robin.
   always_comb begin
      lock_hold = locked && b_req && b_lock && (!a_req || (burst_cnt < CW'(MAX_BURST)));
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      if (!reset) begin
         if (lock_hold) begin
            b_gnt = 1'b1;
         end else if (a_req && b_req) begin
            if (last_gnt == SEL_B) a_gnt = 1'b1;
            else                   b_gnt = 1'b1;
         end else if (a_req) begin
            a_gnt = 1'b1;
         end else if (b_req) begin
            b_gnt = 1'b1;
         end
      end
   end

   // RAM port mux; address/data default to A when idle (don't-care).
   always_comb begin
      ram_en    = a_gnt | b_gnt;
      ram_we    = 1'b0;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
      if (a_gnt) begin
         ram_we = a_we;
      end else if (b_gnt) begin
         ram_we    = b_we;
         ram_addr  = b_addr;
         ram_wdata = b_wdata;
      end
   end

   assign cnt_inc = (burst_cnt < CW'(MAX_BURST)) ? burst_cnt + CW'(1) : burst_cnt;

   // Arbitration history, burst lock and read-owner tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt  <= SEL_B;
         locked    <= 1'b0;
         burst_cnt <= '0;
         rd_owner  <= OWN_NONE;
      end else begin
         if (a_gnt)      last_gnt <= SEL_A;
         else if (b_gnt) last_gnt <= SEL_B;

         // Reaching the limit with A waiting drops the lock so A wins next cycle.
         if (b_gnt && b_lock) begin
            if (a_req) begin
               if (cnt_inc == CW'(MAX_BURST)) begin
                  locked    <= 1'b0;
                  burst_cnt <= '0;
               end else begin
                  locked    <= 1'b1;
                  burst_cnt <= cnt_inc;
               end
            end else begin
               locked <= 1'b1;
            end
         end else begin
            locked    <= 1'b0;
            burst_cnt <= '0;
         end

         if (a_gnt && !a_we)      rd_owner <= OWN_A;
         else if (b_gnt && !b_we) rd_owner <= OWN_B;
         else                     rd_owner <= OWN_NONE;
      end
   end

   assign a_rvalid = (rd_owner == OWN_A);
   assign b_rvalid = (rd_owner == OWN_B);
   assign a_rdata  = ram_rdata;
   assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_j1b_ram_arbiter.sv
// Self-checking bench for j1b_ram_arbiter: vector tables, a RAM model and a
// read-return scoreboard fed by the expected grants.
module tb_j1b_ram_arbiter;

   localparam int unsigned AW        = 13;
   localparam int unsigned DW        = 32;
   localparam int unsigned MAX_BURST = 16;
   localparam int unsigned DEPTH     = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_we, a_gnt, a_rvalid;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata, a_rdata;
   logic          b_req, b_we, b_lock, b_gnt, b_rvalid;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_rdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   j1b_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, one-cycle read latency, read-before-write.
   logic [DW-1:0] mem    [0:DEPTH-1];
   logic [DW-1:0] shadow [0:DEPTH-1];
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= mem[ram_addr];
         if (ram_we) mem[ram_addr] <= ram_wdata;
      end
   end

   typedef struct {
      logic          a_req, a_we;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_wdata;
      logic          b_req, b_we, b_lock;
      logic [AW-1:0] b_addr;
      logic [DW-1:0] b_wdata;
      logic          ea, eb;
   } vec_t;

   typedef struct packed {
      logic          port;   // 0 = A, 1 = B
      logic [DW-1:0] data;
   } ret_t;

   ret_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic vec_t mk(input int ar, input int aw, input int aa, input logic [DW-1:0] ad,
                               input int br, input int bw, input int bl, input int ba,
                               input logic [DW-1:0] bd, input int ea, input int eb);
      vec_t v;
      v.a_req  = 1'(ar);  v.a_we = 1'(aw);  v.a_addr = AW'(aa);  v.a_wdata = ad;
      v.b_req  = 1'(br);  v.b_we = 1'(bw);  v.b_lock = 1'(bl);
      v.b_addr = AW'(ba); v.b_wdata = bd;
      v.ea     = 1'(ea);  v.eb = 1'(eb);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_returns();
      ret_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("a_rvalid", 32'(a_rvalid), 32'(!e.port));
         chk("b_rvalid", 32'(b_rvalid), 32'(e.port));
         if (e.port) chk("b_rdata", b_rdata, e.data);
         else        chk("a_rdata", a_rdata, e.data);
      end else begin
         chk("a_rvalid_idle", 32'(a_rvalid), 32'd0);
         chk("b_rvalid_idle", 32'(b_rvalid), 32'd0);
      end
   endtask

   task automatic drive(input vec_t v);
      a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
      b_req = v.b_req; b_we = v.b_we; b_lock = v.b_lock; b_addr = v.b_addr; b_wdata = v.b_wdata;
   endtask

   // One clock cycle: drive after the edge, check at the falling edge.
   task automatic step(input vec_t v);
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      check_returns();
      chk("a_gnt", 32'(a_gnt), 32'(v.ea));
      chk("b_gnt", 32'(b_gnt), 32'(v.eb));
      chk("ram_en", 32'(ram_en), 32'(v.ea | v.eb));
      if (v.ea) begin
         chk("ram_we_a", 32'(ram_we), 32'(v.a_we));
         chk("ram_addr_a", 32'(ram_addr), 32'(v.a_addr));
         if (v.a_we) begin
            chk("ram_wdata_a", ram_wdata, v.a_wdata);
            shadow[v.a_addr] = v.a_wdata;
         end else begin
            exp_q.push_back({1'b0, shadow[v.a_addr]});
         end
      end else if (v.eb) begin
         chk("ram_we_b", 32'(ram_we), 32'(v.b_we));
         chk("ram_addr_b", 32'(ram_addr), 32'(v.b_addr));
         if (v.b_we) begin
            chk("ram_wdata_b", ram_wdata, v.b_wdata);
            shadow[v.b_addr] = v.b_wdata;
         end else begin
            exp_q.push_back({1'b1, shadow[v.b_addr]});
         end
      end
   endtask

   // Reset for a cycle with A requesting a write: nothing may be granted.
   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      drive(mk(1, 1, 7, 32'hFFFF_FFFF, 1, 1, 1, 7, 32'hEEEE_EEEE, 0, 0));
      exp_q.delete();
      @(negedge clk);
      chk("rst_a_gnt", 32'(a_gnt), 32'd0);
      chk("rst_b_gnt", 32'(b_gnt), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   // Request inputs must hold while waiting for a grant (dropping is allowed).
   logic          pa_wait = 1'b0, pb_wait = 1'b0;
   logic [45:0]   pa_bus, pb_bus;
   logic [46:0]   pb_bus_l;
   always @(posedge clk) begin
      if (!reset && pa_wait && a_req && ({a_we, a_addr, a_wdata} !== pa_bus)) begin
         n_err++;
         $display("FAIL a_stable: A inputs changed while waiting (t=%0t)", $time);
      end
      if (!reset && pb_wait && b_req && ({b_lock, b_we, b_addr, b_wdata} !== pb_bus_l)) begin
         n_err++;
         $display("FAIL b_stable: B inputs changed while waiting (t=%0t)", $time);
      end
      pa_wait  = !reset && a_req && !a_gnt;
      pb_wait  = !reset && b_req && !b_gnt;
      pa_bus   = {a_we, a_addr, a_wdata};
      pb_bus   = {b_we, b_addr, b_wdata};
      pb_bus_l = {b_lock, b_we, b_addr, b_wdata};
   end

   vec_t basic [$];
   vec_t rbw   [$];

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem[i]    = 32'hA500_0000 | 32'(i);
         shadow[i] = 32'hA500_0000 | 32'(i);
      end
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Single-master write/read, B idle.
      basic.push_back(mk(1, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0));
      basic.push_back(mk(1, 0, 5, 0,             0, 0, 0, 0, 0, 1, 0));
      basic.push_back(mk(0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0));
      // Read-before-write on word 3, then a dropped request.
      rbw.push_back(mk(1, 1, 3, 32'h0BAD_F00D, 0, 0, 0, 0, 0,             1, 0));
      rbw.push_back(mk(1, 0, 3, 0,             0, 0, 0, 0, 0,             1, 0));
      rbw.push_back(mk(0, 0, 0, 0,             1, 1, 0, 3, 32'hDEAD_BEEF, 0, 1));
      rbw.push_back(mk(1, 0, 3, 0,             0, 0, 0, 0, 0,             1, 0));
      rbw.push_back(mk(1, 0, 40, 0,            1, 0, 0, 41, 0,            0, 1));
      rbw.push_back(mk(0, 0, 0, 0,             0, 0, 0, 0, 0,             0, 0));
      rbw.push_back(mk(0, 0, 0, 0,             0, 0, 0, 0, 0,             0, 0));

      repeat (2) @(posedge clk);
      do_reset();
      foreach (basic[i]) step(basic[i]);

      // Continuous contention without lock: A first, then strict alternation.
      do_reset();
      for (int k = 0; k < 10; k++)
         step(mk(1, 0, 200 + (k + 1) / 2, 0,
                 1, (k / 2) % 2, 0, 300 + k / 2, 32'hB000_0000 + 32'(k / 2),
                 (k % 2 == 0) ? 1 : 0, (k % 2 == 1) ? 1 : 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 300, 0, 0, 0));

      // Locked burst with A waiting: A, 16 x B, A, then B again.
      do_reset();
      for (int k = 0; k < 20; k++)
         step(mk(1, 0, 20, 0, 1, 0, 1, 100, 0,
                 (k == 0 || k == 17) ? 1 : 0, (k == 0 || k == 17) ? 0 : 1));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Lock with A idle holds the port; A then gets in on the 17th cycle.
      do_reset();
      for (int k = 0; k < 40; k++)
         step(mk(0, 0, 0, 0, 1, 0, 1, 100, 0, 0, 1));
      for (int k = 0; k <= int'(MAX_BURST); k++)
         step(mk(1, 0, 21, 0, 1, 0, 1, 100, 0,
                 (k == int'(MAX_BURST)) ? 1 : 0, (k == int'(MAX_BURST)) ? 0 : 1));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset right after a granted read cancels its return; A wins next.
      do_reset();
      step(mk(1, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0));
      @(posedge clk); #1;
      reset = 1'b1;
      drive(mk(1, 0, 9, 0, 1, 0, 1, 10, 0, 0, 0));
      #1;
      chk("rst_mid_a_rvalid", 32'(a_rvalid), 32'd0);
      @(negedge clk);
      chk("rst_mid_a_gnt", 32'(a_gnt), 32'd0);
      chk("rst_mid_b_gnt", 32'(b_gnt), 32'd0);
      chk("rst_mid_ram_en", 32'(ram_en), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk(1, 0, 11, 0, 1, 0, 0, 12, 0, 1, 0));
      step(mk(0, 0, 0, 0,  1, 0, 0, 12, 0, 0, 1));
      step(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

      // Read-before-write and dropped request.
      do_reset();
      foreach (rbw[i]) step(rbw[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
